// File: rtl/ctrl_pkg.sv
// Shared encodings for the multicycle controller: opcodes, FSM states,
// instruction classes and the writeback/PC mux selects.
package ctrl_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IARITH = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_IWAIT  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_MWAIT  = 3'd5,
    S_WB     = 3'd6,
    S_HALT   = 3'd7
  } state_t;

  typedef enum logic [3:0] {
    C_R, C_IARITH, C_LOAD, C_STORE, C_BRANCH,
    C_JAL, C_JALR, C_LUI, C_AUIPC, C_ILLEGAL
  } iclass_t;

  typedef enum logic [1:0] {
    WB_ALU = 2'd0,
    WB_MEM = 2'd1,
    WB_PC4 = 2'd2,
    WB_IMM = 2'd3
  } wb_sel_t;

  typedef enum logic [1:0] {
    PC_PLUS4 = 2'd0,
    PC_IMM   = 2'd1,
    PC_JALR  = 2'd2
  } pc_sel_t;

endpackage

// File: rtl/multicycle_ctrl_opcode_classify.sv
// Combinational opcode decoder: maps instr[6:0] onto an instruction class.
module opcode_classify
  import ctrl_pkg::*;
(
  input  logic [6:0] opcode,
  output iclass_t    iclass
);

  always_comb begin
    iclass = C_ILLEGAL;
    case (opcode)
      OP_R:      iclass = C_R;
      OP_IARITH: iclass = C_IARITH;
      OP_LOAD:   iclass = C_LOAD;
      OP_STORE:  iclass = C_STORE;
      OP_BRANCH: iclass = C_BRANCH;
      OP_JAL:    iclass = C_JAL;
      OP_JALR:   iclass = C_JALR;
      OP_LUI:    iclass = C_LUI;
      OP_AUIPC:  iclass = C_AUIPC;
      default:   iclass = C_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle fetch/decode/execute/memory/writeback controller.
// Define MULTICYCLE_CTRL_INSTRET_EN to build the retired-instruction counter.
module multicycle_ctrl
  import ctrl_pkg::*;
#(
  parameter bit ILLEGAL_HALT = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        dmem_req_valid,
  input  logic        dmem_req_ready,
  output logic        dmem_we,
  input  logic        dmem_rsp_valid,
  input  logic        branch_cond,
  output logic        pc_we,
  output logic        rf_we,
  output logic        alu_src_imm,
  output logic [1:0]  wb_sel,
  output logic [1:0]  pc_sel,
  output logic        halted,
  output logic [2:0]  state_dbg,
  output logic [31:0] instret
);

  state_t  state, state_nxt;
  iclass_t iclass;
  logic    bcond_p1;
  logic    uses_imm;
  logic    is_mem;

  opcode_classify u_classify (
    .opcode (instr[6:0]),
    .iclass (iclass)
  );

  assign uses_imm  = (iclass != C_R) && (iclass != C_BRANCH);
  assign is_mem    = (iclass == C_LOAD) || (iclass == C_STORE);
  assign state_dbg = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_FETCH;
      instr    <= INSTR_NOP;
      bcond_p1 <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == S_IWAIT && imem_rsp_valid) instr <= imem_rdata;
      if (state == S_EXEC) bcond_p1 <= branch_cond;
    end
  end

  always_comb begin
    state_nxt      = state;
    imem_req_valid = 1'b0;
    dmem_req_valid = 1'b0;
    dmem_we        = 1'b0;
    pc_we          = 1'b0;
    rf_we          = 1'b0;
    alu_src_imm    = 1'b0;
    wb_sel         = WB_ALU;
    pc_sel         = PC_PLUS4;
    halted         = 1'b0;
    case (state)
      S_FETCH: begin
        // Held low while rst is high so every output reads 0 during reset.
        imem_req_valid = !rst;
        if (imem_req_ready) state_nxt = S_IWAIT;
      end
      S_IWAIT: if (imem_rsp_valid) state_nxt = S_DECODE;
      S_DECODE: begin
        if (iclass == C_ILLEGAL) state_nxt = ILLEGAL_HALT ? S_HALT : S_WB;
        else                     state_nxt = S_EXEC;
      end
      S_EXEC: begin
        alu_src_imm = uses_imm;
        state_nxt   = is_mem ? S_MEM : S_WB;
      end
      S_MEM: begin
        alu_src_imm    = uses_imm;
        dmem_req_valid = 1'b1;
        dmem_we        = (iclass == C_STORE);
        if (dmem_req_ready) state_nxt = S_MWAIT;
      end
      S_MWAIT: begin
        alu_src_imm = uses_imm;
        if (dmem_rsp_valid) state_nxt = S_WB;
      end
      S_WB: begin
        alu_src_imm = uses_imm;
        pc_we       = 1'b1;
        state_nxt   = S_FETCH;
        case (iclass)
          C_R, C_IARITH, C_AUIPC: rf_we = 1'b1;
          C_LOAD:   begin rf_we = 1'b1; wb_sel = WB_MEM; end
          C_JAL:    begin rf_we = 1'b1; wb_sel = WB_PC4; pc_sel = PC_IMM; end
          C_JALR:   begin rf_we = 1'b1; wb_sel = WB_PC4; pc_sel = PC_JALR; end
          C_LUI:    begin rf_we = 1'b1; wb_sel = WB_IMM; end
          C_BRANCH: if (bcond_p1) pc_sel = PC_IMM;
          default:  ;
        endcase
      end
      S_HALT: halted = 1'b1;
      default: state_nxt = S_FETCH;
    endcase
  end

`ifdef MULTICYCLE_CTRL_INSTRET_EN
  logic [31:0] instret_q;

  always_ff @(posedge clk) begin
    if (rst)                instret_q <= '0;
    else if (state == S_WB) instret_q <= instret_q + 32'd1;
  end

  assign instret = instret_q;
`else
  assign instret = '0;
`endif

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 SHALL have parameter ILLEGAL_HALT, default 1, meaning: 1 = illegal opcode enters HALT; 0 = illegal opcode retires as NOP.
REQ-002 SHALL have ports `clk` (in, 1) and `rst` (in, 1); one clock; reset is synchronous and active-high.
REQ-003 SHALL have ports `imem_req_valid` (out, 1), `imem_req_ready` (in, 1), `imem_rsp_valid` (in, 1) and `imem_rdata` (in, 32), forming the instruction-fetch handshake.
REQ-004 SHALL have port `instr` (out, 32): the latched instruction register, which feeds the immediate generator and the register file addresses.
REQ-005 SHALL have ports `dmem_req_valid` (out, 1), `dmem_req_ready` (in, 1), `dmem_we` (out, 1) and `dmem_rsp_valid` (in, 1), forming the data-memory handshake.
REQ-006 SHALL have ports `branch_cond` (in, 1): the ALU compare result, valid in EXEC.
REQ-007 SHALL have ports `pc_we` (out, 1), `rf_we` (out, 1), `alu_src_imm` (out, 1), `wb_sel` (out, 2) and `pc_sel` (out, 2), which are the datapath controls.
REQ-008 SHALL have ports `halted` (out, 1), `state_dbg` (out, 3) and `instret` (out, 32).

Function
REQ-009 SHALL implement states FETCH, IWAIT, DECODE, EXEC, MEM, MWAIT, WB and HALT.
REQ-010 In FETCH, SHALL assert imem_req_valid and hold it until imem_req_ready=1, then go to IWAIT.
REQ-011 In IWAIT, SHALL capture imem_rdata into instr on the cycle imem_rsp_valid=1, then go to DECODE; instr is stable from DECODE until the next IWAIT capture.
REQ-012 In DECODE, SHALL classify instr[6:0] as one of: R (0110011), I-arith, load, store, branch, JAL, JALR, LUI, AUIPC or illegal; illegal goes to HALT if ILLEGAL_HALT=1, else to WB with rf_we=0.
REQ-013 In EXEC, SHALL drive alu_src_imm=1 for every class except R and branch; loads/stores go to MEM, all other classes go to WB.
REQ-014 In MEM, SHALL assert dmem_req_valid (dmem_we=1 for store only) and hold it until dmem_req_ready=1, then go to MWAIT; MWAIT waits for dmem_rsp_valid=1, then goes to WB.
REQ-015 In WB, SHALL pulse pc_we for exactly 1 cycle, and rf_we for exactly 1 cycle for R, I-arith, load, JAL, JALR, LUI and AUIPC; then go to FETCH.
REQ-016 wb_sel encoding: 0=ALU, 1=memory, 2=PC+4, 3=immediate (LUI).
REQ-017 pc_sel encoding: 0=PC+4, 1=PC+imm (JAL, or branch with branch_cond=1), 2=ALU&~1 (JALR).
REQ-018 branch_cond SHALL be sampled in EXEC and held in a register for WB.
REQ-019 Minimum latency with zero-wait memory (ready and rsp in the first cycle): 5 cycles for non-memory instructions, 7 cycles for load/store.
REQ-020 imem_rsp_valid outside IWAIT and dmem_rsp_valid outside MWAIT SHALL be ignored.
REQ-021 HALT is absorbing: halted=1, no requests, no write enables; only rst exits it.
REQ-022 instret SHALL increment by 1 in each WB cycle and wrap from 0xFFFFFFFF to 0.
REQ-023 state_dbg SHALL equal the state encoding defined in the package.

Reset
REQ-024 On rst=1 at a clock edge, SHALL enter FETCH, abandoning any in-flight handshake.
REQ-025 Reset values: instr=0x00000013 (NOP), instret=0, all outputs 0 except state_dbg=FETCH.
REQ-026 imem_req_valid SHALL assert on the first cycle after rst deasserts.
REQ-027 Reset mid-MEM SHALL drop dmem_req_valid in the cycle the reset takes effect.

Configuration
REQ-028 With MULTICYCLE_CTRL_INSTRET_EN defined, SHALL include the instret counter; without it, instret SHALL be tied to 0 with the port retained and no counter flops.

Structure
REQ-029 Package ctrl_pkg SHALL hold: the opcode constants, the state encoding, the instruction-class enum, and the wb_sel/pc_sel encodings; the immediate generator shares the opcode constants.
REQ-030 SHALL use one combinational sub-module, opcode_classify: instr[6:0] -> class.

Verification
REQ-031 Zero-wait memory, instr 0x00500093 (ADDI x1,x0,5) -> rf_we=1 in cycle 5, wb_sel=0, alu_src_imm=1, pc_sel=0, instret=1.
REQ-032 Instr 0x0000A103 (LW), dmem_req_ready delayed 3 cycles -> dmem_req_valid held 4 cycles, dmem_we=0, rf_we=1 with wb_sel=1, total 10 cycles.
REQ-033 Instr 0x0020A223 (SW) -> dmem_we=1 during MEM, rf_we never asserted, pc_we single pulse.
REQ-034 Instr 0x00000063 (BEQ) with branch_cond=1, then with 0 -> pc_sel=1, then pc_sel=0; rf_we=0 in both cases.
REQ-035 Instr 0xFFFFFFFF with ILLEGAL_HALT=1 -> halted=1 from the cycle after DECODE, no further imem_req_valid; rst then restores FETCH.
REQ-036 rst asserted in MWAIT, with a stray dmem_rsp_valid in the following cycle -> FETCH, instret unchanged, response ignored.
